// File: rtl/mem_pkg.sv
// Shared types and widths for the memory-access stage.
// Imported by the MEM/WB stage and its sub-modules.
package mem_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 32;
    localparam int PC_W       = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Byte-addressed data memory: synchronous write, asynchronous read.
// Contents are never cleared; reset leaves the array untouched.
module data_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Store lands at the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register.
// Multi-cycle loads stall upstream; branches/jumps redirect fetch.
module mem_wb_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] MEM_aluout,
    input  logic [DATA_W-1:0] MEM_read_data2,
    input  logic [31:0]       MEM_reg_write_addr,
    input  logic [31:0]       MEM_branch_addr,
    input  logic [31:0]       MEM_jump_addr,
    input  logic              MEM_zr,
    input  logic              MEM_ng,
    input  logic              MEM_cr,
    input  logic              MEM_ov,
    input  logic              MEM_Branch,
    input  logic              MEM_BranchFlip,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic              MEM_Jump,
    input  logic              MEM_RegWrite,
    input  logic              MEM_MemtoReg,
    output logic [DATA_W-1:0] WB_aluout,
    output logic [DATA_W-1:0] WB_read_data,
    output logic [31:0]       WB_reg_write_addr,
    output logic              WB_RegWrite,
    output logic              WB_MemtoReg,
    output logic              pc_src,
    output logic [31:0]       pc_target,
    output logic              flush,
    output logic              stall
);

    import mem_pkg::*;

    localparam logic [2:0] CNT_INIT =
        (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] wb_aluout_q, wb_aluout_d;
    logic [DATA_W-1:0] wb_read_data_q, wb_read_data_d;
    logic [31:0]       wb_dst_q, wb_dst_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic              wb_memtoreg_q, wb_memtoreg_d;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic              rd_req;
    logic              stall_c;
    logic              rd_done;
    logic              taken;
    logic              unused_flags;

    assign addr         = MEM_aluout[ADDR_W-1:0];
    assign rd_req       = MEM_MemRead & ~MEM_MemWrite;
    assign unused_flags = ^{MEM_ng, MEM_cr, MEM_ov};

    data_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dmem (
        .clk   (clk),
        .we    (MEM_MemWrite & ~rst),
        .addr  (addr),
        .wdata (MEM_read_data2),
        .rdata (rdata)
    );

    // Load sequencer: stall for MEM_LAT-1 cycles, complete on the last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        rd_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    if (MEM_LAT <= 1) begin
                        rd_done = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 3'd0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                end else begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign stall = stall_c & ~rst;

    // Branch/jump resolution; jump target wins over branch target.
    always_comb begin
        taken     = MEM_Branch & (MEM_zr ^ MEM_BranchFlip);
        pc_target = MEM_Jump ? MEM_jump_addr : MEM_branch_addr;
        pc_src    = ~rst & (MEM_Jump | taken);
        flush     = pc_src;
    end

    // MEM/WB next values: bubble while stalled, else capture.
    always_comb begin
        wb_aluout_d    = wb_aluout_q;
        wb_read_data_d = wb_read_data_q;
        wb_dst_d       = wb_dst_q;
        wb_regwrite_d  = 1'b0;
        wb_memtoreg_d  = 1'b0;
        if (!stall_c) begin
            wb_aluout_d   = MEM_aluout;
            wb_dst_d      = MEM_reg_write_addr;
            wb_regwrite_d = MEM_RegWrite;
            wb_memtoreg_d = MEM_MemtoReg;
            if (rd_done) begin
                wb_read_data_d = rdata;
            end
        end
    end

    // State and MEM/WB register; reset abandons any pending load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            wb_aluout_q    <= '0;
            wb_read_data_q <= '0;
            wb_dst_q       <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wb_aluout_q    <= wb_aluout_d;
            wb_read_data_q <= wb_read_data_d;
            wb_dst_q       <= wb_dst_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
        end
    end

    assign WB_aluout         = wb_aluout_q;
    assign WB_read_data      = wb_read_data_q;
    assign WB_reg_write_addr = wb_dst_q;
    assign WB_RegWrite       = wb_regwrite_q;
    assign WB_MemtoReg       = wb_memtoreg_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage at MEM_LAT=2 and MEM_LAT=4.
// One shared stimulus bus; controls are gated to the selected instance.
module tb_mem_wb_stage;

    typedef struct {
        logic [7:0]  alu;
        logic [7:0]  rdat;
        logic [31:0] dst;
        logic        m2r;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [7:0]  aluout;
    logic [7:0]  wdata;
    logic [31:0] dst;
    logic [31:0] br_addr;
    logic [31:0] j_addr;
    logic        zr, flip, br, jmp, mrd, mwr, rw, m2r;

    logic [7:0]  wb_alu2, wb_rd2, wb_alu4, wb_rd4;
    logic [31:0] wb_dst2, wb_dst4, pct2, pct4;
    logic        wb_rw2, wb_m2r2, pcs2, fl2, st2;
    logic        wb_rw4, wb_m2r4, pcs4, fl4, st4;

    int checks = 0;
    int errors = 0;
    exp_t q2[$];
    exp_t q4[$];

    mem_wb_stage #(.ADDR_W(8), .MEM_LAT(2), .DATA_W(8)) u2 (
        .clk(clk), .rst(rst),
        .MEM_aluout(aluout), .MEM_read_data2(wdata),
        .MEM_reg_write_addr(dst), .MEM_branch_addr(br_addr),
        .MEM_jump_addr(j_addr),
        .MEM_zr(zr), .MEM_ng(1'b0), .MEM_cr(1'b0), .MEM_ov(1'b0),
        .MEM_Branch(br & ~sel), .MEM_BranchFlip(flip),
        .MEM_MemRead(mrd & ~sel), .MEM_MemWrite(mwr & ~sel),
        .MEM_Jump(jmp & ~sel), .MEM_RegWrite(rw & ~sel),
        .MEM_MemtoReg(m2r & ~sel),
        .WB_aluout(wb_alu2), .WB_read_data(wb_rd2),
        .WB_reg_write_addr(wb_dst2), .WB_RegWrite(wb_rw2),
        .WB_MemtoReg(wb_m2r2), .pc_src(pcs2), .pc_target(pct2),
        .flush(fl2), .stall(st2)
    );

    mem_wb_stage #(.ADDR_W(8), .MEM_LAT(4), .DATA_W(8)) u4 (
        .clk(clk), .rst(rst),
        .MEM_aluout(aluout), .MEM_read_data2(wdata),
        .MEM_reg_write_addr(dst), .MEM_branch_addr(br_addr),
        .MEM_jump_addr(j_addr),
        .MEM_zr(zr), .MEM_ng(1'b1), .MEM_cr(1'b1), .MEM_ov(1'b1),
        .MEM_Branch(br & sel), .MEM_BranchFlip(flip),
        .MEM_MemRead(mrd & sel), .MEM_MemWrite(mwr & sel),
        .MEM_Jump(jmp & sel), .MEM_RegWrite(rw & sel),
        .MEM_MemtoReg(m2r & sel),
        .WB_aluout(wb_alu4), .WB_read_data(wb_rd4),
        .WB_reg_write_addr(wb_dst4), .WB_RegWrite(wb_rw4),
        .WB_MemtoReg(wb_m2r4), .pc_src(pcs4), .pc_target(pct4),
        .flush(fl4), .stall(st4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic nop();
        br = 0; flip = 0; jmp = 0; zr = 0;
        mrd = 0; mwr = 0; rw = 0; m2r = 0;
    endtask

    // Present one instruction; hold it while the selected DUT stalls.
    task automatic issue(input string nm, input logic s,
                         input logic [7:0] a, input logic [7:0] wd,
                         input logic [31:0] d, input logic r,
                         input logic w, input logic rwi,
                         input logic m, input logic [7:0] exp_rd,
                         input int exp_stall);
        int  n;
        bit  done;
        exp_t e;
        n = 0;
        done = 0;
        sel = s; aluout = a; wdata = wd; dst = d;
        nop();
        mrd = r; mwr = w; rw = rwi; m2r = m;
        if (rwi) begin
            e.alu = a; e.rdat = exp_rd; e.dst = d; e.m2r = m;
            if (s) q4.push_back(e);
            else q2.push_back(e);
        end
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (n > 0) chk({nm, "_bubble"}, s ? wb_rw4 : wb_rw2, 0);
            if (s ? st4 : st2) begin
                n++;
                @(posedge clk);
            end else begin
                done = 1;
            end
        end
        if (!done) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_stall_cycles"}, n, exp_stall);
        @(posedge clk);
        #1 nop();
    endtask

    task automatic brchk(input string nm, input logic b,
                         input logic f, input logic z,
                         input logic j, input logic exp_src,
                         input logic [31:0] exp_tgt);
        sel = 0; br = b; flip = f; zr = z; jmp = j;
        br_addr = 32'h40; j_addr = 32'h80;
        #1;
        chk({nm, "_pc_src"}, pcs2, exp_src);
        chk({nm, "_flush"}, fl2, exp_src);
        if (exp_src) chk({nm, "_target"}, pct2, exp_tgt);
        nop();
    endtask

    // Each WB write-back is matched against the oldest expectation.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (!rst && wb_rw2) begin
            if (q2.size() == 0) begin
                chk("u2_unexpected_wb", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("u2_aluout", wb_alu2, e.alu);
                chk("u2_dst", wb_dst2, e.dst);
                chk("u2_memtoreg", wb_m2r2, e.m2r);
                if (e.m2r || e.rdat != 8'h00)
                    chk("u2_read_data", wb_rd2, e.rdat);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && wb_rw4) begin
            if (q4.size() == 0) begin
                chk("u4_unexpected_wb", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("u4_aluout", wb_alu4, e.alu);
                chk("u4_dst", wb_dst4, e.dst);
                chk("u4_memtoreg", wb_m2r4, e.m2r);
                if (e.m2r) chk("u4_read_data", wb_rd4, e.rdat);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1; sel = 0; aluout = 0; wdata = 0; dst = 0;
        br_addr = 0; j_addr = 0;
        nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_rw2", wb_rw2, 0);
        chk("rst_wb_alu2", wb_alu2, 0);
        chk("rst_wb_rd4", wb_rd4, 0);
        chk("rst_stall2", st2, 0);
        chk("rst_stall4", st4, 0);
        @(posedge clk);
        #1 rst = 0;

        issue("alu33", 0, 8'h33, 8'h00, 3, 0, 0, 1, 0, 8'h00, 0);
        issue("st10", 0, 8'h10, 8'hA5, 0, 0, 1, 0, 0, 8'h00, 0);
        issue("alu44", 0, 8'h44, 8'h00, 4, 0, 0, 1, 0, 8'h00, 0);
        issue("ld10", 0, 8'h10, 8'h00, 5, 1, 0, 1, 1, 8'hA5, 1);

        brchk("br_taken", 1, 0, 1, 0, 1, 32'h40);
        brchk("br_flip", 1, 1, 1, 0, 0, 32'h40);
        brchk("br_flip_nz", 1, 1, 0, 0, 1, 32'h40);
        brchk("br_nz", 1, 0, 0, 0, 0, 32'h40);
        brchk("jmp_prio", 1, 0, 1, 1, 1, 32'h80);

        issue("stFF", 0, 8'hFF, 8'h3C, 0, 0, 1, 0, 0, 8'h00, 0);
        issue("ldFF", 0, 8'hFF, 8'h00, 6, 1, 0, 1, 1, 8'h3C, 1);
        issue("rdwr20", 0, 8'h20, 8'h77, 7, 1, 1, 1, 0, 8'h3C, 0);
        issue("ld20", 0, 8'h20, 8'h00, 8, 1, 0, 1, 1, 8'h77, 1);

        issue("st01", 1, 8'h01, 8'h11, 0, 0, 1, 0, 0, 8'h00, 0);
        issue("st02", 1, 8'h02, 8'h22, 0, 0, 1, 0, 0, 8'h00, 0);
        issue("ld01", 1, 8'h01, 8'h00, 9, 1, 0, 1, 1, 8'h11, 3);
        issue("ld02", 1, 8'h02, 8'h00, 10, 1, 0, 1, 1, 8'h22, 3);

        issue("alu5A", 1, 8'h5A, 8'h00, 11, 0, 0, 1, 0, 8'h00, 0);
        sel = 1; aluout = 8'h01; dst = 13;
        mrd = 1; rw = 1; m2r = 1; jmp = 1; j_addr = 32'h80;
        @(posedge clk);
        #3;
        chk("busy_stall4", st4, 1);
        chk("busy_pc_src4", pcs4, 1);
        rst = 1;
        #1;
        chk("arst_stall4", st4, 0);
        chk("arst_pc_src4", pcs4, 0);
        chk("arst_flush4", fl4, 0);
        chk("arst_wb_rw4", wb_rw4, 0);
        chk("arst_wb_alu4", wb_alu4, 0);
        chk("arst_wb_rd4", wb_rd4, 0);
        chk("arst_wb_dst4", wb_dst4, 0);
        chk("arst_wb_m2r4", wb_m2r4, 0);
        nop();
        @(posedge clk);
        #1 rst = 0;

        issue("post_ld02", 1, 8'h02, 8'h00, 12, 1, 0, 1, 1, 8'h22, 3);
        issue("post_ld01", 1, 8'h01, 8'h00, 14, 1, 0, 1, 1, 8'h11, 3);
        issue("post_ldFF", 0, 8'hFF, 8'h00, 15, 1, 0, 1, 1, 8'h3C, 1);

        repeat (3) @(negedge clk);
        chk("q2_drained", q2.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register. Performs data-memory loads and stores and resolves branch/jump redirection to the fetch stage. Registers write-back data and control into the WB stage. Loads run with a configurable multi-cycle latency and stall the upstream pipeline while they are pending.

Parameters:
ADDR_W, 8, data-memory address width; depth = 2**ADDR_W bytes; indexed by MEM_aluout[ADDR_W-1:0]
MEM_LAT, 2, load latency in cycles (legal 1..4); 1 = no stall
DATA_W, 8, datapath width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
MEM_aluout  in  8  ALU result: memory address, or write-back value
MEM_read_data2  in  8  store data
MEM_reg_write_addr  in  32  destination register index
MEM_branch_addr  in  32  branch target
MEM_jump_addr  in  32  jump target
MEM_zr, MEM_ng, MEM_cr, MEM_ov  in  1 each  ALU flags (only zr used for decisions)
MEM_Branch, MEM_BranchFlip, MEM_MemRead, MEM_MemWrite, MEM_Jump, MEM_RegWrite, MEM_MemtoReg  in  1 each  control
WB_aluout  out  8  registered ALU result
WB_read_data  out  8  registered load data
WB_reg_write_addr  out  32  registered destination
WB_RegWrite, WB_MemtoReg  out  1 each  registered control
pc_src  out  1  redirect fetch this cycle
pc_target  out  32  redirect target
flush  out  1  squash the younger in-flight instructions (equals pc_src)
stall  out  1  upstream stages and the EX/MEM register hold while high

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high.
  - All WB_* outputs go to 0, FSM to IDLE, cnt to 0.
  - stall, pc_src and flush are forced to 0 while rst is high.
  - Data-memory contents are not cleared.
  - Reset during a pending load abandons the load: no write-back, and the FSM returns to IDLE.
- Branch/jump resolution (combinational):
  - taken = MEM_Branch & (MEM_zr ^ MEM_BranchFlip).
  - Jump has priority: pc_target = MEM_Jump ? MEM_jump_addr : MEM_branch_addr.
  - pc_src = MEM_Jump | taken.
- Store: when MEM_MemWrite=1, dmem[addr] <= MEM_read_data2 at the edge. Single cycle, no stall.
  - If MemWrite and MemRead are both set, the store wins, no read occurs and no stall is raised.
- Load FSM, states IDLE and BUSY, 3-bit counter cnt:
  - IDLE, MemRead=1, MEM_LAT=1: read completes in the same cycle; stall=0.
  - IDLE, MemRead=1, MEM_LAT>1: stall=1; next state BUSY with cnt <= MEM_LAT-2.
  - BUSY, cnt!=0: stall=1, cnt decrements.
  - BUSY, cnt=0: stall=0; read data is captured into WB_read_data at this edge; next state IDLE.
  - Net effect: a load occupies MEM_LAT cycles, with stall high for MEM_LAT-1 of them.
  - A back-to-back load (the next instruction is also a load) re-enters BUSY from IDLE on the following cycle. There is no dead cycle beyond the latency.
- Memory read: asynchronous array read at addr, sampled in the completing cycle. A load issued in the cycle after a store to the same address returns the new data.
- MEM/WB register (every edge):
  - While stall=1: insert a bubble (WB_RegWrite<=0, WB_MemtoReg<=0; other WB_* hold).
  - Otherwise: capture WB_aluout<=MEM_aluout, WB_reg_write_addr<=MEM_reg_write_addr, WB_RegWrite, WB_MemtoReg. WB_read_data <= dmem[addr] when MemRead, else it holds.
- Width rules:
  - Address = MEM_aluout[ADDR_W-1:0]; upper bits are ignored, so the address wraps modulo depth.
  - Flags ng, cr, ov are accepted but unused.

Decomposition:
- Shared package mem_pkg holds: FSM state enum (IDLE, BUSY), DATA_W=8, REG_ADDR_W=32, PC_W=32.
- One natural sub-module: data_mem (sync write, async read, parameter ADDR_W), instantiated once.
- FSM, branch logic and the MEM/WB register stay in mem_wb_stage.

Test Plan:
- Store then load, MEM_LAT=2: store 0xA5 to addr 0x10; next cycle load addr 0x10 -> stall high 1 cycle; WB_read_data=0xA5, WB_MemtoReg=1, WB_RegWrite=1 one edge after stall drops; bubble (WB_RegWrite=0) during the stall edge.
- Branch: Branch=1, zr=1, Flip=0, branch_addr=0x40 -> pc_src=1, flush=1, pc_target=0x40. With Flip=1 -> pc_src=0.
- Jump priority: Jump=1, Branch=1, zr=1, jump_addr=0x80, branch_addr=0x40 -> pc_target=0x80, pc_src=1.
- MEM_LAT=4 back-to-back loads from 0x01 and 0x02 (preloaded 0x11, 0x22) -> stall high 3 cycles, low 1, high 3; WB_read_data 0x11 then 0x22.
- Reset mid-load: assert rst asynchronously in BUSY -> stall and all WB_* go to 0 immediately. After release the FSM is IDLE, and preloaded memory still reads back unchanged.
- Address wrap, ADDR_W=8: store 0x3C to aluout 0xFF, load 0xFF -> 0x3C. MemRead and MemWrite both set -> write occurs, stall=0.
